undo_history_ctrl: RTL and testbench

- Bounded LIFO history of game-state snapshots backing the retract (undo) path of the game controller.
- Each accepted move pushes the pre-move 135-bit game state. A retract pops the most recent snapshot, which the game-state mux loads when the controller selects the retract source.
- A stage init or retry clears the history.
- Also maintains the player-visible step counter for the score display.

---
 rtl/undo_history_ctrl.sv | 103 ++++++++++
 tb/tb_undo_history_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/undo_history_ctrl.sv
// Bounded LIFO of pre-move game-state snapshots for the retract path, plus the
// player-visible net step counter. Oldest snapshot is overwritten once full.
module undo_history_ctrl #(
    parameter int WIDTH  = 135,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int STEP_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic              pop_valid,
    output logic              pop_err,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic [STEP_W-1:0] steps
);

    localparam logic [AW:0]       DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     head_q,      head_d;
    logic [AW:0]       count_q,     count_d;
    logic [STEP_W-1:0] steps_q,     steps_d;
    logic [WIDTH-1:0]  pop_data_q,  pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              pop_err_q,   pop_err_d;
    logic              wr_en;
    logic [AW-1:0]     head_prev;

    // head is AW bits wide, so the decrement wraps modulo DEPTH by itself
    assign head_prev = head_q - 1'b1;

    always_comb begin
        head_d      = head_q;
        count_d     = count_q;
        steps_d     = steps_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        pop_err_d   = 1'b0;
        wr_en       = 1'b0;
        if (clear) begin
            head_d  = '0;
            count_d = '0;
            steps_d = '0;
        end else if (pop) begin
            if (count_q != '0) begin
                pop_data_d  = mem_q[head_prev];
                head_d      = head_prev;
                count_d     = count_q - 1'b1;
                steps_d     = (steps_q == '0) ? '0 : steps_q - 1'b1;
                pop_valid_d = 1'b1;
            end else begin
                pop_err_d = 1'b1;
            end
        end else if (push) begin
            wr_en   = 1'b1;
            head_d  = head_q + 1'b1;
            count_d = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
            steps_d = (steps_q == STEP_MAX) ? steps_q : steps_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            count_q     <= '0;
            steps_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            pop_err_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            count_q     <= count_d;
            steps_q     <= steps_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            pop_err_q   <= pop_err_d;
        end
    end

    // Snapshot storage carries no reset; count/head decide what is live.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[head_q] <= push_data;
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign pop_err   = pop_err_q;
    assign count     = count_q;
    assign steps     = steps_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_undo_history_ctrl.sv
// Directed bench for undo_history_ctrl: LIFO order, wrap-around, priority,
// clear/reset behaviour and step counter saturation.
module tb_undo_history_ctrl;

    localparam int WIDTH  = 135;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int STEP_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              push;
    logic [WIDTH-1:0]  push_data;
    logic              pop;
    logic [WIDTH-1:0]  pop_data;
    logic              pop_valid;
    logic              pop_err;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic [STEP_W-1:0] steps;

    int n_checks = 0;
    int n_pass   = 0;

    undo_history_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .pop_err   (pop_err),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .steps     (steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Snapshot pattern exercising the upper, middle and lower bits of the bus
    function automatic logic [WIDTH-1:0] snap(input int v);
        logic [63:0] w;
        w = 64'(v);
        return {7'h55, w, ~w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        push      = 1'b1;
        push_data = d;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        tick(); tick();
        check("rst_pop_data", pop_data, '0);
        check("rst_pop_valid", WIDTH'(pop_valid), '0);
        check("rst_pop_err", WIDTH'(pop_err), '0);
        check("rst_empty", WIDTH'(empty), 1);
        check("rst_full", WIDTH'(full), '0);
        check("rst_count", WIDTH'(count), '0);
        check("rst_steps", WIDTH'(steps), '0);
        reset = 1'b0;

        // pop on empty
        do_pop();
        check("empty_pop_err", WIDTH'(pop_err), 1);
        check("empty_pop_valid", WIDTH'(pop_valid), '0);
        check("empty_pop_count", WIDTH'(count), '0);
        check("empty_pop_data", pop_data, '0);
        tick();
        check("empty_pop_err_pulse", WIDTH'(pop_err), '0);

        // basic LIFO order
        do_push(snap(1)); do_push(snap(2)); do_push(snap(3));
        check("lifo_count", WIDTH'(count), 3);
        check("lifo_steps", WIDTH'(steps), 3);
        check("lifo_empty", WIDTH'(empty), '0);
        for (int i = 3; i >= 1; i--) begin
            do_pop();
            check($sformatf("lifo_pop_data%0d", i), pop_data, snap(i));
            check($sformatf("lifo_pop_valid%0d", i), WIDTH'(pop_valid), 1);
            check($sformatf("lifo_pop_err%0d", i), WIDTH'(pop_err), '0);
        end
        tick();
        check("lifo_valid_drop", WIDTH'(pop_valid), '0);
        check("lifo_end_count", WIDTH'(count), '0);
        check("lifo_end_empty", WIDTH'(empty), 1);
        check("lifo_end_steps", WIDTH'(steps), '0);

        // overflow wrap-around
        for (int i = 1; i <= 10; i++) do_push(snap(i));
        check("wrap_full", WIDTH'(full), 1);
        check("wrap_count", WIDTH'(count), 8);
        check("wrap_steps", WIDTH'(steps), 10);
        for (int i = 10; i >= 3; i--) begin
            do_pop();
            check($sformatf("wrap_pop_data%0d", i), pop_data, snap(i));
            check($sformatf("wrap_pop_valid%0d", i), WIDTH'(pop_valid), 1);
        end
        do_pop();
        check("wrap_ninth_err", WIDTH'(pop_err), 1);
        check("wrap_ninth_valid", WIDTH'(pop_valid), '0);
        check("wrap_ninth_data_held", pop_data, snap(3));
        check("wrap_steps_after", WIDTH'(steps), 2);
        check("wrap_count_after", WIDTH'(count), '0);

        // push and pop in the same cycle: pop wins, push discarded
        clear = 1'b1; tick();
        do_push(snap(16'hA)); do_push(snap(16'hB));
        push = 1'b1; push_data = snap(16'hC); pop = 1'b1; tick();
        check("prio_pop_data", pop_data, snap(16'hB));
        check("prio_count", WIDTH'(count), 1);
        check("prio_steps", WIDTH'(steps), 1);
        do_pop();
        check("prio_next_pop", pop_data, snap(16'hA));
        check("prio_count_after", WIDTH'(count), '0);

        // clear beats pop and push; pop_data is not zeroed by clear
        for (int i = 20; i < 25; i++) do_push(snap(i));
        check("clr_pre_count", WIDTH'(count), 5);
        clear = 1'b1; push = 1'b1; push_data = snap(99); pop = 1'b1; tick();
        check("clr_count", WIDTH'(count), '0);
        check("clr_steps", WIDTH'(steps), '0);
        check("clr_pop_valid", WIDTH'(pop_valid), '0);
        check("clr_pop_err", WIDTH'(pop_err), '0);
        check("clr_pop_data_held", pop_data, snap(16'hA));
        do_pop();
        check("clr_following_pop_err", WIDTH'(pop_err), 1);

        // pop right after push
        do_push(snap(16'h77));
        do_pop();
        check("pp_pop_data", pop_data, snap(16'h77));
        check("pp_pop_valid", WIDTH'(pop_valid), 1);

        // steps saturate at all-ones, then decrement on pop
        for (int i = 0; i < 1030; i++) do_push(snap(i));
        check("sat_steps", WIDTH'(steps), 1023);
        check("sat_count", WIDTH'(count), 8);
        do_pop();
        check("sat_pop_steps", WIDTH'(steps), 1022);
        check("sat_pop_data", pop_data, snap(1029));

        // reset right after a pop strobe
        pop = 1'b1; reset = 1'b1; tick();
        reset = 1'b0;
        check("mid_rst_pop_valid", WIDTH'(pop_valid), '0);
        check("mid_rst_pop_data", pop_data, '0);
        check("mid_rst_count", WIDTH'(count), '0);
        check("mid_rst_steps", WIDTH'(steps), '0);
        check("mid_rst_empty", WIDTH'(empty), 1);
        check("mid_rst_full", WIDTH'(full), '0);
        check("mid_rst_pop_err", WIDTH'(pop_err), '0);
        do_push(snap(5));
        do_pop();
        check("post_rst_pop", pop_data, snap(5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
